// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: ALU control codes,
// arbiter FSM states and the legality check for control codes.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_OP_AND = 4'b0000,
        ALU_OP_OR  = 4'b0001,
        ALU_OP_ADD = 4'b0010,
        ALU_OP_SUB = 4'b0110,
        ALU_OP_SLT = 4'b0111,
        ALU_OP_NOR = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // True when the control code is one the ALU implements.
    function automatic logic is_legal_op(input logic [3:0] ctrl);
        logic legal;
        case (ctrl)
            ALU_OP_AND, ALU_OP_OR, ALU_OP_ADD,
            ALU_OP_SUB, ALU_OP_SLT, ALU_OP_NOR: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: picks the first requester at or after
// ptr, searching upward and wrapping. The pointer itself lives in the caller.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan the N positions starting at ptr; the first valid one wins.
    always_comb begin
        logic             w_found;
        logic [IDX_W-1:0] w_idx;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = IDX_W'((int'(ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found          = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. A request is
// accepted in IDLE, its operands drive the ALU for one EXEC cycle, and the
// captured result is held in RESP until the owning requester accepts it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0][3:0]         req_ctrl,
    output logic [WIDTH-1:0]                alu_a,
    output logic [WIDTH-1:0]                alu_b,
    output logic [3:0]                      alu_ctrl,
    input  logic [WIDTH-1:0]                alu_result,
    input  logic                            alu_zero,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [WIDTH-1:0]                rsp_result,
    output logic                            rsp_zero,
    output logic                            rsp_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_err;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic [3:0]           r_alu_ctrl;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_result;
    logic                 r_rsp_zero;
    logic                 r_rsp_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W-1:0]     w_ptr_next;
    logic                 w_handshake;
    logic                 w_rsp_done;
    logic                 w_legal;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_handshake = (r_state == IDLE) && (|w_grant);
    assign w_rsp_done  = (r_state == RESP) && rsp_ready[r_owner];
    assign w_legal     = is_legal_op(req_ctrl[w_grant_idx]);

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_ctrl   = r_alu_ctrl;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

    // Pointer advances to the slot just past the winner, wrapping at NUM_REQ.
    always_comb begin
        w_ptr_next = '0;
        if (w_grant_idx == IDX_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant_idx + IDX_W'(1);
        end
    end

    // Accept is offered only to the winner, only in IDLE, and never during reset.
    always_comb begin
        req_ready = '0;
        if ((r_state == IDLE) && rst_n) begin
            req_ready = w_grant;
        end else begin
            req_ready = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on owner accept.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_handshake ? EXEC : IDLE;
            EXEC:    w_next_state = RESP;
            RESP:    w_next_state = w_rsp_done ? IDLE : RESP;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latch on accept, result capture after EXEC, response release on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_owner      <= '0;
            r_err        <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= 4'b0000;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_alu_a    <= req_a[w_grant_idx];
                        r_alu_b    <= req_b[w_grant_idx];
                        // Illegal codes still run, but the ALU sees a harmless AND.
                        r_alu_ctrl <= w_legal ? req_ctrl[w_grant_idx] : ALU_OP_AND;
                        r_err      <= ~w_legal;
                        r_owner    <= w_grant_idx;
                        r_ptr      <= w_ptr_next;
                    end else begin
                        r_ptr <= r_ptr;
                    end
                end
                EXEC: begin
                    r_rsp_valid  <= NUM_REQ'(1) << r_owner;
                    r_rsp_result <= r_err ? '0 : alu_result;
                    r_rsp_zero   <= r_err ? 1'b1 : alu_zero;
                    r_rsp_err    <= r_err;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= '0;
                    end else begin
                        r_rsp_valid <= r_rsp_valid;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the
// shared ALU port. Inputs change and outputs are sampled on the falling edge.
module tb_alu_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0][3:0]   req_ctrl;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_ctrl;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    int n_total = 0;
    int n_bad   = 0;

    alu_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One isolated operation from requester idx with rsp_ready held high.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, input logic [3:0] exp_ctrl,
                         input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
        req_valid      = 2'b00;
        req_valid[idx] = 1'b1;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_ctrl[idx]  = ctrl;
        rsp_ready      = 2'b11;
        #1 check_eq("op_ready", {30'd0, req_ready}, 32'd1 << idx);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq("op_alu_a", alu_a, a);
        check_eq("op_alu_b", alu_b, b);
        check_eq("op_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, exp_ctrl});
        check_eq("op_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("op_rsp_valid", {30'd0, rsp_valid}, 32'd1 << idx);
        check_eq("op_rsp_result", rsp_result, exp_res);
        check_eq("op_rsp_zero", {31'd0, rsp_zero}, {31'd0, exp_zero});
        check_eq("op_rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        @(negedge clk);
        #1 check_eq("op_rsp_clear", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_result", rsp_result, 32'd0);
        check_eq("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Isolated operations; pointer walks 0->1->0->1->0->1->0.
        do_op(0, 32'd5, 32'd3, 4'b0010, 4'b0010, 32'd8, 1'b0, 1'b0);
        do_op(1, 32'd7, 32'd7, 4'b0110, 4'b0110, 32'd0, 1'b1, 1'b0);
        do_op(0, 32'd1, 32'd2, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b1);
        do_op(1, 32'd3, 32'd7, 4'b1000, 4'b0000, 32'd0, 1'b1, 1'b1);
        do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 4'b0111, 32'd1, 1'b0, 1'b0);
        do_op(1, 32'd0, 32'd0, 4'b1100, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Contention: both valid all the time, grants alternate every 3 cycles.
        req_a[0] = 32'd10; req_b[0] = 32'd4; req_ctrl[0] = 4'b0010;
        req_a[1] = 32'd10; req_b[1] = 32'd4; req_ctrl[1] = 4'b0110;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("cont_ready", {30'd0, req_ready}, 32'd1 << (k % 2));
            @(negedge clk);
            #1 check_eq("cont_exec_ready", {30'd0, req_ready}, 32'd0);
            @(negedge clk);
            #1;
            check_eq("cont_rsp_valid", {30'd0, rsp_valid}, 32'd1 << (k % 2));
            check_eq("cont_rsp_result", rsp_result, (k % 2 == 0) ? 32'd14 : 32'd6);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Backpressure on requester 0 while requester 1 waits; pointer is 0.
        req_a[0] = 32'hF0; req_b[0] = 32'h3C; req_ctrl[0] = 4'b0000;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        #1 check_eq("bp_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_a[1] = 32'd9; req_b[1] = 32'd1; req_ctrl[1] = 4'b0010;
        req_valid = 2'b10;
        #1 check_eq("bp_exec_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1 check_eq("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_ready = 2'b10;
            #1;
            check_eq("bp_hold_valid", {30'd0, rsp_valid}, 32'd1);
            check_eq("bp_hold_result", rsp_result, 32'h30);
            check_eq("bp_hold_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
            check_eq("bp_hold_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        check_eq("bp_release_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("bp_next_grant", {30'd0, req_ready}, 32'd2);
        rsp_ready = 2'b11;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check_eq("bp_r1_valid", {30'd0, rsp_valid}, 32'd2);
        check_eq("bp_r1_result", rsp_result, 32'd10);
        @(negedge clk);

        // Reset during EXEC; pointer is 0 and becomes 1 on this accept.
        req_a[0] = 32'd3; req_b[0] = 32'd4; req_ctrl[0] = 4'b0010;
        req_valid = 2'b01;
        #1 check_eq("rm_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rm_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_eq("rm_req_ready", {30'd0, req_ready}, 32'd0);
        check_eq("rm_rsp_result", rsp_result, 32'd0);
        check_eq("rm_alu_a", alu_a, 32'd0);
        check_eq("rm_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        req_valid = 2'b00;
        repeat (2) begin
            @(negedge clk);
            #1 check_eq("rm_hold_valid", {30'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_eq("rm_post_valid", {30'd0, rsp_valid}, 32'd0);
        req_valid = 2'b11;
        #1 check_eq("rm_first_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check_eq("rm_rsp_valid2", {30'd0, rsp_valid}, 32'd1);
        check_eq("rm_rsp_result2", rsp_result, 32'd7);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
